mpsoc_dbg_wb_arbiter: RTL and testbench

Round-robin Wishbone B3 arbiter that shares one Wishbone master port between `NUM_MASTERS` requesters, typically the debug WB BIU and one or more CPU data/instruction masters. It sits between the WB debug module and the system interconnect. Ownership is granted per bus cycle: the owner keeps the bus from `cyc` assertion to `cyc` release, including classic and incrementing bursts. An optional watchdog aborts hung slave accesses.

---
 rtl/mpsoc_dbg_wb_arbiter.sv | 262 ++++++++++++++++++++++++++
 tb/tb_mpsoc_dbg_wb_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpsoc_dbg_wb_arbiter.sv
// -----------------------------------------------------------------------------
// mpsoc_dbg_wb_arbiter
//
// Round-robin Wishbone B3 arbiter. NUM_MASTERS requesters share a single
// Wishbone master port towards the system interconnect. Master 0 is normally
// the debug BIU. Ownership is held for a whole bus cycle, from cyc assertion
// to cyc release, so classic and incrementing bursts are never split.
//
// Optional feature (compile-time macro):
//   MPSOC_DBG_WB_ARB_TIMEOUT_EN - adds a watchdog. When it fires, the owner
//   gets an m_err_o pulse, the slave cycle is dropped, and the arbiter waits
//   in ABORT until the owner releases cyc.
//
// Ports (per-master buses flattened, master i occupies slice i):
//   wb_clk_i, wb_rst_ni         clock, asynchronous active-low reset
//   m_cyc_i/m_stb_i/m_we_i      [NUM_MASTERS]      master cycle/strobe/write
//   m_sel_i                     [NUM_MASTERS*SEL]  byte selects
//   m_adr_i                     [NUM_MASTERS*AW]   addresses
//   m_dat_i                     [NUM_MASTERS*DW]   write data
//   m_cti_i/m_bte_i             [NUM_MASTERS*3/2]  burst tags
//   m_dat_o                     [DW]               read data (broadcast)
//   m_ack_o/m_err_o             [NUM_MASTERS]      per-master termination
//   s_cyc_o..s_bte_o                               shared slave request
//   s_dat_i, s_ack_i, s_err_i                      slave response
//   grant_o                     [NUM_MASTERS]      one-hot owner, 0 when idle
// -----------------------------------------------------------------------------
module mpsoc_dbg_wb_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                                wb_clk_i,
  input  logic                                wb_rst_ni,

  input  logic [NUM_MASTERS-1:0]              m_cyc_i,
  input  logic [NUM_MASTERS-1:0]              m_stb_i,
  input  logic [NUM_MASTERS-1:0]              m_we_i,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_sel_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]   m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]   m_dat_i,
  input  logic [NUM_MASTERS*3-1:0]            m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]            m_bte_i,
  output logic [DATA_WIDTH-1:0]               m_dat_o,
  output logic [NUM_MASTERS-1:0]              m_ack_o,
  output logic [NUM_MASTERS-1:0]              m_err_o,

  output logic                                s_cyc_o,
  output logic                                s_stb_o,
  output logic                                s_we_o,
  output logic [DATA_WIDTH/8-1:0]             s_sel_o,
  output logic [ADDR_WIDTH-1:0]               s_adr_o,
  output logic [DATA_WIDTH-1:0]               s_dat_o,
  output logic [2:0]                          s_cti_o,
  output logic [1:0]                          s_bte_o,
  input  logic [DATA_WIDTH-1:0]               s_dat_i,
  input  logic                                s_ack_i,
  input  logic                                s_err_i,

  output logic [NUM_MASTERS-1:0]              grant_o
);

  localparam int SEL_WIDTH = DATA_WIDTH / 8;
  localparam int IDX_W     = $clog2(NUM_MASTERS);

  typedef logic [IDX_W-1:0] idx_t;

`ifdef MPSOC_DBG_WB_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2
  } state_t;
`else
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;
`endif

  state_t state_reg, state_next;
  idx_t   gnt_idx_reg, gnt_idx_next;
  idx_t   last_idx_reg, last_idx_next;

  // ---------------------------------------------------------------------------
  // Per-master views of the flattened request buses
  // ---------------------------------------------------------------------------
  logic [SEL_WIDTH-1:0]  sel_arr [NUM_MASTERS];
  logic [ADDR_WIDTH-1:0] adr_arr [NUM_MASTERS];
  logic [DATA_WIDTH-1:0] dat_arr [NUM_MASTERS];
  logic [2:0]            cti_arr [NUM_MASTERS];
  logic [1:0]            bte_arr [NUM_MASTERS];

  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
      assign sel_arr[gi] = m_sel_i[gi*SEL_WIDTH  +: SEL_WIDTH];
      assign adr_arr[gi] = m_adr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign dat_arr[gi] = m_dat_i[gi*DATA_WIDTH +: DATA_WIDTH];
      assign cti_arr[gi] = m_cti_i[gi*3 +: 3];
      assign bte_arr[gi] = m_bte_i[gi*2 +: 2];
    end
  endgenerate

  logic busy;
  logic owner_cyc;
  logic owner_stb;
  logic timeout_hit;

  assign busy      = (state_reg == ST_BUSY);
  assign owner_cyc = m_cyc_i[gnt_idx_reg];
  assign owner_stb = m_stb_i[gnt_idx_reg];

  // ---------------------------------------------------------------------------
  // Round-robin pick: lowest requester above last_idx wins, otherwise wrap to
  // the lowest requester at or below it. The descending scan leaves the lowest
  // matching index in each candidate.
  // ---------------------------------------------------------------------------
  idx_t rr_pick;
  idx_t pick_hi, pick_lo;
  logic found_hi;

  always_comb begin
    pick_hi  = '0;
    pick_lo  = '0;
    found_hi = 1'b0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (m_cyc_i[i]) begin
        if (idx_t'(i) > last_idx_reg) begin
          pick_hi  = idx_t'(i);
          found_hi = 1'b1;
        end else begin
          pick_lo = idx_t'(i);
        end
      end
    end
    rr_pick = found_hi ? pick_hi : pick_lo;
  end

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
`ifdef MPSOC_DBG_WB_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;

  // A response in the same cycle as expiry wins: the access completed.
  assign timeout_hit = busy && owner_cyc && !s_ack_i && !s_err_i &&
                       (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES));

  always_comb begin
    tmo_cnt_next = '0;
    if (busy && owner_cyc && !s_ack_i && !s_err_i && !timeout_hit) begin
      tmo_cnt_next = owner_stb ? tmo_cnt_reg + 1'b1 : tmo_cnt_reg;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      tmo_cnt_reg <= '0;
    end else begin
      tmo_cnt_reg <= tmo_cnt_next;
    end
  end
`else
  assign timeout_hit = 1'b0;

  // TIMEOUT_CYCLES only has meaning with the watchdog built in.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^{1'b0, TIMEOUT_CYCLES[0]};
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    gnt_idx_next  = gnt_idx_reg;
    last_idx_next = last_idx_reg;
    case (state_reg)
      ST_IDLE: begin
        if (|m_cyc_i) begin
          gnt_idx_next = rr_pick;
          state_next   = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (!owner_cyc) begin
          last_idx_next = gnt_idx_reg;
          state_next    = ST_IDLE;
        end else if (timeout_hit) begin
`ifdef MPSOC_DBG_WB_ARB_TIMEOUT_EN
          state_next = ST_ABORT;
`endif
        end
      end
`ifdef MPSOC_DBG_WB_ARB_TIMEOUT_EN
      ST_ABORT: begin
        if (!owner_cyc) begin
          last_idx_next = gnt_idx_reg;
          state_next    = ST_IDLE;
        end
      end
`endif
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_reg    <= ST_IDLE;
      gnt_idx_reg  <= '0;
      // Starting at the top index makes master 0 the first winner.
      last_idx_reg <= idx_t'(NUM_MASTERS - 1);
    end else begin
      state_reg    <= state_next;
      gnt_idx_reg  <= gnt_idx_next;
      last_idx_reg <= last_idx_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Slave-side request mux. cyc/stb fall combinationally with the owner's cyc
  // so the release cycle already shows an idle bus to the slave.
  // ---------------------------------------------------------------------------
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_sel_o = '0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_cti_o = '0;
    s_bte_o = '0;
    if (busy) begin
      s_cyc_o = owner_cyc & ~timeout_hit;
      s_stb_o = owner_cyc & owner_stb & ~timeout_hit;
      s_we_o  = m_we_i[gnt_idx_reg];
      s_sel_o = sel_arr[gnt_idx_reg];
      s_adr_o = adr_arr[gnt_idx_reg];
      s_dat_o = dat_arr[gnt_idx_reg];
      s_cti_o = cti_arr[gnt_idx_reg];
      s_bte_o = bte_arr[gnt_idx_reg];
    end
  end

  assign m_dat_o = s_dat_i;

  // ---------------------------------------------------------------------------
  // Grant and termination routing: only the owner sees ack/err.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_route
      assign grant_o[gi] = busy && (gnt_idx_reg == idx_t'(gi));
      assign m_ack_o[gi] = grant_o[gi] & s_ack_i;
      assign m_err_o[gi] = grant_o[gi] & (s_err_i | timeout_hit);
    end
  endgenerate

endmodule

// File: tb/tb_mpsoc_dbg_wb_arbiter.sv
// -----------------------------------------------------------------------------
// Self-checking bench for mpsoc_dbg_wb_arbiter (2 masters, 32-bit bus).
// A transaction-level ownership model (current owner, last owner, optional
// watchdog count) predicts every output each cycle; directed scenarios add
// hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_mpsoc_dbg_wb_arbiter;

  localparam int NM  = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int SW  = DW / 8;
  localparam int TMO = 8;

  logic              clk;
  logic              rst_n;
  logic [NM-1:0]     m_cyc, m_stb, m_we;
  logic [NM*SW-1:0]  m_sel;
  logic [NM*AW-1:0]  m_adr;
  logic [NM*DW-1:0]  m_dat;
  logic [NM*3-1:0]   m_cti;
  logic [NM*2-1:0]   m_bte;
  logic [DW-1:0]     m_dat_o;
  logic [NM-1:0]     m_ack_o, m_err_o;
  logic              s_cyc_o, s_stb_o, s_we_o;
  logic [SW-1:0]     s_sel_o;
  logic [AW-1:0]     s_adr_o;
  logic [DW-1:0]     s_dat_o;
  logic [2:0]        s_cti_o;
  logic [1:0]        s_bte_o;
  logic [DW-1:0]     s_dat;
  logic              s_ack, s_err;
  logic [NM-1:0]     grant_o;

  int checks = 0;
  int errors = 0;

  mpsoc_dbg_wb_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_MASTERS(NM), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_sel_i(m_sel),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_cti_i(m_cti), .m_bte_i(m_bte),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_dat_i(s_dat), .s_ack_i(s_ack), .s_err_i(s_err),
    .grant_o(grant_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Ownership model: who owns the bus, who owned it last, watchdog progress.
  // ---------------------------------------------------------------------------
  int model_owner;    // -1 when nobody owns the bus
  int model_last;
  bit model_aborted;
  int model_tmo;

  function automatic bit model_tmo_hit();
`ifdef MPSOC_DBG_WB_ARB_TIMEOUT_EN
    return (model_owner >= 0) && !model_aborted && m_cyc[model_owner] &&
           !s_ack && !s_err && (model_tmo == TMO);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_owner   = -1;
      model_last    = NM - 1;
      model_aborted = 0;
      model_tmo     = 0;
    end else if (model_owner < 0) begin
      model_tmo = 0;
      for (int k = 1; k <= NM; k++) begin
        if (model_owner < 0 && m_cyc[(model_last + k) % NM])
          model_owner = (model_last + k) % NM;
      end
    end else if (!m_cyc[model_owner]) begin
      model_last    = model_owner;
      model_owner   = -1;
      model_aborted = 0;
      model_tmo     = 0;
    end else if (!model_aborted) begin
      if (model_tmo_hit()) begin
        model_aborted = 1;
        model_tmo     = 0;
      end else if (s_ack || s_err) begin
        model_tmo = 0;
      end else if (m_stb[model_owner]) begin
        model_tmo++;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin : cmp
    logic [NM-1:0] e_grant, e_ack, e_err;
    logic          e_cyc, e_stb, e_we;
    logic [SW-1:0] e_sel;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    logic [2:0]    e_cti;
    logic [1:0]    e_bte;
    bit            hit;
    int            o;
    e_grant = '0; e_ack = '0; e_err = '0;
    e_cyc = 0; e_stb = 0; e_we = 0;
    e_sel = '0; e_adr = '0; e_dat = '0; e_cti = '0; e_bte = '0;
    o   = model_owner;
    hit = model_tmo_hit();
    if (o >= 0 && !model_aborted) begin
      e_grant[o] = 1'b1;
      e_ack[o]   = s_ack;
      e_err[o]   = s_err | hit;
      e_cyc      = m_cyc[o] & !hit;
      e_stb      = m_cyc[o] & m_stb[o] & !hit;
      e_we       = m_we[o];
      e_sel      = m_sel[o*SW +: SW];
      e_adr      = m_adr[o*AW +: AW];
      e_dat      = m_dat[o*DW +: DW];
      e_cti      = m_cti[o*3 +: 3];
      e_bte      = m_bte[o*2 +: 2];
    end
    chk("model_grant", grant_o, e_grant);
    chk("model_ack",   m_ack_o, e_ack);
    chk("model_err",   m_err_o, e_err);
    chk("model_cyc",   s_cyc_o, e_cyc);
    chk("model_stb",   s_stb_o, e_stb);
    chk("model_we",    s_we_o,  e_we);
    chk("model_sel",   s_sel_o, e_sel);
    chk("model_adr",   s_adr_o, e_adr);
    chk("model_wdat",  s_dat_o, e_dat);
    chk("model_cti",   s_cti_o, e_cti);
    chk("model_bte",   s_bte_o, e_bte);
    chk("model_rdat",  m_dat_o, s_dat);
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    m_cyc = '0; m_stb = '0; m_we = '0; m_sel = '0; m_adr = '0; m_dat = '0;
    m_cti = '0; m_bte = '0; s_dat = '0; s_ack = 1'b0; s_err = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_grant(output int cycles);
    cycles = 0;
    while (grant_o == '0 && cycles < 8) begin
      step();
      cycles++;
    end
  endtask

  int w;

  initial begin
    rst_n = 1'b0;
    clear_inputs();

    // Reset state: requests and a stray ack must not reach any output.
    m_cyc = 2'b11; m_stb = 2'b11; s_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_grant", grant_o, 0);
    chk("reset_cyc",   s_cyc_o, 0);
    chk("reset_ack",   m_ack_o, 0);
    $display("txn reset: grant=%b s_cyc=%b m_ack=%b", grant_o, s_cyc_o, m_ack_o);

    // Single read by master 1.
    do_reset();
    m_cyc = 2'b10; m_stb = 2'b10; m_adr[63:32] = 32'h0000_1000; m_sel[7:4] = 4'hF;
    settle();
    chk("t1_idle_grant", grant_o, 0);
    step();
    chk("t1_grant", grant_o, 2'b10);
    chk("t1_cyc",   s_cyc_o, 1);
    chk("t1_adr",   s_adr_o, 32'h0000_1000);
    s_ack = 1'b1; s_dat = 32'hDEAD_BEEF;
    settle();
    chk("t1_ack", m_ack_o, 2'b10);
    chk("t1_dat", m_dat_o, 32'hDEAD_BEEF);
    $display("txn read m1: grant=%b ack=%b dat=%h", grant_o, m_ack_o, m_dat_o);
    step();
    s_ack = 1'b0; m_cyc = '0; m_stb = '0;
    settle();
    chk("t1_ack_clear", m_ack_o, 0);
    step();
    chk("t1_idle_after", grant_o, 0);

    // Both masters continuously requesting: grants alternate 0,1,0,1 with a
    // two-cycle handoff from release to the next grant.
    do_reset();
    m_cyc = 2'b11; m_stb = 2'b11;
    m_adr[31:0] = 32'h100; m_adr[63:32] = 32'h200;
    for (int n = 0; n < 4; n++) begin
      int o;
      o = n % 2;
      wait_grant(w);
      if (n == 0) chk("t2_latency", w, 1);
      else        chk("t2_handoff_gap", w + 1, 2);
      chk("t2_owner", grant_o, 64'(1) << o);
      $display("txn rr grant %0d: grant=%b", n, grant_o);
      s_ack = 1'b1; s_dat = 32'h5000 + n;
      step();
      s_ack = 1'b0; m_cyc[o] = 1'b0; m_stb[o] = 1'b0;
      settle();
      chk("t2_release_cyc", s_cyc_o, 0);
      step();
      m_cyc[o] = 1'b1; m_stb[o] = 1'b1;
    end

    // 4-beat incrementing burst by master 0 while master 1 waits. The final
    // ack arrives in the cycle master 0 drops cyc and must still reach it.
    do_reset();
    m_cyc = 2'b11; m_stb = 2'b11; m_cti[2:0] = 3'b010; m_bte = '0;
    m_adr[31:0] = 32'h2000;
    step();
    for (int b = 0; b < 4; b++) begin
      m_adr[31:0] = 32'h2000 + 32'(4 * b);
      if (b == 3) begin
        m_cti[2:0] = 3'b111; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
      end
      s_ack = 1'b1; s_dat = 32'hA0 + 32'(b);
      settle();
      chk("t3_grant", grant_o, 2'b01);
      chk("t3_ack",   m_ack_o, 2'b01);
      if (b < 3) chk("t3_cti", s_cti_o, 3'b010);
      else       chk("t3_last_cyc", s_cyc_o, 0);
      $display("txn burst beat %0d: grant=%b ack=%b adr=%h", b, grant_o, m_ack_o, s_adr_o);
      step();
    end
    s_ack = 1'b0;
    settle();
    chk("t3_dead_cycle", grant_o, 0);
    step();
    chk("t3_m1_grant", grant_o, 2'b10);

    // Error on a master 1 write.
    do_reset();
    m_cyc = 2'b10; m_stb = 2'b10; m_we = 2'b10; m_sel[7:4] = 4'hF;
    m_dat[63:32] = 32'h1234_5678; m_adr[63:32] = 32'h300;
    step();
    s_err = 1'b1;
    settle();
    chk("t4_err",  m_err_o, 2'b10);
    chk("t4_ack",  m_ack_o, 0);
    chk("t4_we",   s_we_o, 1);
    chk("t4_wdat", s_dat_o, 32'h1234_5678);
    $display("txn err m1: err=%b ack=%b grant=%b", m_err_o, m_ack_o, grant_o);
    step();
    s_err = 1'b0;
    settle();
    chk("t4_err_pulse", m_err_o, 0);
    chk("t4_held", grant_o, 2'b10);
    m_cyc = '0; m_stb = '0;
    step();
    chk("t4_released", grant_o, 0);

`ifdef MPSOC_DBG_WB_ARB_TIMEOUT_EN
    // Watchdog: no slave response.
    do_reset();
    m_cyc = 2'b01; m_stb = 2'b01;
    step();
    chk("t5_stb_rise", s_stb_o, 1);
    for (int k = 1; k < TMO; k++) begin
      step();
      chk("t5_no_err_yet", m_err_o, 0);
    end
    step();
    chk("t5_err_pulse", m_err_o, 2'b01);
    chk("t5_cyc_drop", s_cyc_o, 0);
    $display("txn timeout: err=%b s_cyc=%b", m_err_o, s_cyc_o);
    step();
    chk("t5_abort_cyc", s_cyc_o, 0);
    chk("t5_abort_err", m_err_o, 0);
    m_cyc = '0; m_stb = '0;
    step();
    chk("t5_idle", grant_o, 0);
`endif

    // Asynchronous reset in the middle of a burst.
    do_reset();
    m_cyc = 2'b11; m_stb = 2'b11; m_cti[2:0] = 3'b010;
    step();
    s_ack = 1'b1;
    step();
    step();
    settle();
    chk("t6_pre_ack", m_ack_o, 2'b01);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_cyc",   s_cyc_o, 0);
    chk("t6_rst_grant", grant_o, 0);
    chk("t6_rst_ack",   m_ack_o, 0);
    $display("txn async reset: s_cyc=%b grant=%b ack=%b", s_cyc_o, grant_o, m_ack_o);
    step();
    s_ack = 1'b0;
    rst_n = 1'b1;
    step();
    chk("t6_first_grant", grant_o, 2'b01);

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
